// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths, update-mode constants and the
// retune state encoding used by the phase accumulator and downstream stages.
package dds_pkg;

  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 9;

  // upd_mode encodings
  localparam logic UPD_IMMEDIATE = 1'b0;
  localparam logic UPD_DEFERRED  = 1'b1;

  typedef enum logic {
    UpdIdle    = 1'b0,
    UpdPending = 1'b1
  } upd_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: integrates the frequency word, adds the phase
// offset and registers the waveform-table address. Frequency/phase words can
// take effect immediately or be held in shadows until the next wrap.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              upd_mode,
  input  logic              fw_ld,
  input  logic [ACC_W-1:0]  fw_in,
  input  logic              pw_ld,
  input  logic [ADDR_W-1:0] pw_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wrap_out,
  output logic              pending
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  fw_act_q, fw_act_d;
  logic [ACC_W-1:0]  fw_sh_q, fw_sh_d;
  logic [ADDR_W-1:0] pw_act_q, pw_act_d;
  logic [ADDR_W-1:0] pw_sh_q, pw_sh_d;
  upd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Carry of the accumulator add, delayed one stage so wrap_out lines up with
  // the first post-wrap address rather than the last pre-wrap one.
  logic              acc_wrap_q, acc_wrap_d;
  logic              wrap_out_q, wrap_out_d;
  logic [ACC_W:0]    sum;
  logic              take_now;

  // Accumulator next state and carry-out detection.
  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, fw_act_q};
    acc_d      = acc_q;
    acc_wrap_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d      = sum[ACC_W-1:0];
      acc_wrap_d = sum[ACC_W];
    end
  end

  // Table address from the accumulator's top bits plus phase offset.
  always_comb begin
    addr_d     = acc_q[ACC_W-1 -: ADDR_W] + pw_act_q;
    wrap_out_d = acc_wrap_q;
  end

  // Word update control: loads land in shadows; active words change either
  // immediately or on the wrap edge, a load on the wrap edge bypassing the shadow.
  always_comb begin
    fw_sh_d  = fw_ld ? fw_in : fw_sh_q;
    pw_sh_d  = pw_ld ? pw_in : pw_sh_q;
    fw_act_d = fw_act_q;
    pw_act_d = pw_act_q;
    state_d  = state_q;
    take_now = (upd_mode == UPD_IMMEDIATE) || acc_wrap_d;

    if (take_now) begin
      if (state_q == UpdPending) begin
        fw_act_d = fw_sh_q;
        pw_act_d = pw_sh_q;
      end
      if (fw_ld) fw_act_d = fw_in;
      if (pw_ld) pw_act_d = pw_in;
      state_d = UpdIdle;
    end else if (fw_ld || pw_ld) begin
      state_d = UpdPending;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      fw_act_q   <= '0;
      fw_sh_q    <= '0;
      pw_act_q   <= '0;
      pw_sh_q    <= '0;
      state_q    <= UpdIdle;
      addr_q     <= '0;
      acc_wrap_q <= 1'b0;
      wrap_out_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fw_act_q   <= fw_act_d;
      fw_sh_q    <= fw_sh_d;
      pw_act_q   <= pw_act_d;
      pw_sh_q    <= pw_sh_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      acc_wrap_q <= acc_wrap_d;
      wrap_out_q <= wrap_out_d;
    end
  end

  assign addr_out = addr_q;
  assign wrap_out = wrap_out_q;
  assign pending  = (state_q == UpdPending);

endmodule
